// File: rtl/led_addr_sequencer.sv
// led_addr_sequencer: LED pattern address counter advanced by divided-clock ticks
// or single steps, with run/pause control and a wrap pulse. Rev 1.0
`default_nettype none

module led_addr_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 15
) (
  input  logic                  sys_clock,
  input  logic                  reset_n,
  input  logic                  div_clk_in,
  input  logic                  run_en,
  input  logic                  step_req,
  input  logic                  dir_up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  wrap,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  generate
    if ((LAST_ADDR < 1) || (LAST_ADDR > (2**ADDR_WIDTH) - 1)) begin : g_bad_last_addr
      $error("led_addr_sequencer: LAST_ADDR must lie in 1..2**ADDR_WIDTH-1");
    end
  endgenerate

  state_t                cur_state;
  state_t                nxt_state;
  logic                  div_q;
  logic                  div_q_d;
  logic                  step_q;
  logic                  step_q_d;
  logic                  tick;
  logic                  step_tick;
  logic                  advance;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  wrap_nxt;

  // Divided clock and step request are sampled as data; rising edges become enables.
  assign tick      = div_q & ~div_q_d;
  assign step_tick = step_q & ~step_q_d;
  assign state     = cur_state;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= 1'b0;
      div_q_d    <= 1'b0;
      step_q     <= 1'b0;
      step_q_d   <= 1'b0;
      cur_state  <= IDLE;
      addr       <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      div_q      <= div_clk_in;
      div_q_d    <= div_q;
      step_q     <= step_req;
      step_q_d   <= step_q;
      cur_state  <= nxt_state;
      addr       <= addr_nxt;
      addr_valid <= (nxt_state != IDLE);
      wrap       <= wrap_nxt;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    advance   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (run_en) begin
          nxt_state = RUN;
        end else if (step_tick) begin
          nxt_state = PAUSE;
          advance   = 1'b1;
        end
      end
      RUN: begin
        // Pausing takes priority over a coincident tick.
        if (!run_en) begin
          nxt_state = PAUSE;
        end else if (tick) begin
          advance = 1'b1;
        end
      end
      PAUSE: begin
        if (run_en) begin
          nxt_state = RUN;
        end else if (step_tick) begin
          advance = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    addr_nxt = addr;
    wrap_nxt = 1'b0;
    if (advance) begin
      if (dir_up) begin
        if (addr == LAST) begin
          addr_nxt = '0;
          wrap_nxt = 1'b1;
        end else begin
          addr_nxt = addr + ONE;
        end
      end else begin
        if (addr == '0) begin
          addr_nxt = LAST;
          wrap_nxt = 1'b1;
        end else begin
          addr_nxt = addr - ONE;
        end
      end
    end
  end

  a_addr_range: assert property (@(posedge sys_clock) disable iff (!reset_n)
    addr <= LAST);

  a_wrap_endpoint: assert property (@(posedge sys_clock) disable iff (!reset_n)
    wrap |-> ((addr == '0) || (addr == LAST)));

  a_valid_decode: assert property (@(posedge sys_clock) disable iff (!reset_n)
    addr_valid == (cur_state != IDLE));

endmodule

`default_nettype wire

// File: tb/tb_led_addr_sequencer.sv
// tb_led_addr_sequencer: table/scoreboard bench for led_addr_sequencer.
`default_nettype none

module tb_led_addr_sequencer;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_R = 2'b01;
  localparam logic [1:0] ST_P = 2'b10;

  logic       sys_clock = 1'b0;
  logic       reset_n;
  logic       div_clk_in, run_en, step_req, dir_up;
  logic [3:0] addr;
  logic       addr_valid, wrap;
  logic [1:0] state;

  logic       div9, run9, step9, dir9;
  logic [3:0] addr9;
  logic       valid9, wrap9;
  logic [1:0] state9;

  led_addr_sequencer #(.ADDR_WIDTH(4), .LAST_ADDR(15)) u_dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .div_clk_in(div_clk_in),
    .run_en(run_en), .step_req(step_req), .dir_up(dir_up),
    .addr(addr), .addr_valid(addr_valid), .wrap(wrap), .state(state));

  led_addr_sequencer #(.ADDR_WIDTH(4), .LAST_ADDR(9)) u_dut9 (
    .sys_clock(sys_clock), .reset_n(reset_n), .div_clk_in(div9),
    .run_en(run9), .step_req(step9), .dir_up(dir9),
    .addr(addr9), .addr_valid(valid9), .wrap(wrap9), .state(state9));

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic       run, dir, div, step;
    logic [3:0] addr;
    logic [1:0] st;
    logic       valid, wrap;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Scoreboard: one expected {addr,state,valid,wrap} per driven cycle, checked after the edge.
  always @(posedge sys_clock) begin
    logic [7:0] e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({addr, state, addr_valid, wrap} !== e) begin
        n_bad++;
        $display("FAIL cycle#%0d: got addr=%0d state=%0d valid=%0b wrap=%0b, expected addr=%0d state=%0d valid=%0b wrap=%0b",
                 n_cmp, addr, state, addr_valid, wrap, e[7:4], e[3:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic d, input logic dv, input logic s,
                     input logic [3:0] ea, input logic [1:0] es, input logic ev, input logic ew);
    @(negedge sys_clock);
    run_en = r; dir_up = d; div_clk_in = dv; step_req = s;
    sb.push_back({ea, es, ev, ew});
    @(posedge sys_clock);
    #2;
  endtask

  // One divided-clock pulse in RUN: sampled edge, update edge, settle.
  task automatic tk(input logic d, input logic [3:0] prev, input logic [3:0] nxt, input logic w);
    cyc(1'b1, d, 1'b1, 1'b0, prev, ST_R, 1'b1, 1'b0);
    cyc(1'b1, d, 1'b0, 1'b0, nxt,  ST_R, 1'b1, w);
    cyc(1'b1, d, 1'b0, 1'b0, nxt,  ST_R, 1'b1, 1'b0);
  endtask

  task automatic add(input logic r, input logic d, input logic dv, input logic s,
                     input logic [3:0] ea, input logic [1:0] es, input logic ev, input logic ew);
    vec_t v;
    v = '{r, d, dv, s, ea, es, ev, ew};
    tbl.push_back(v);
  endtask

  task automatic step9_chk(input logic d, input logic [3:0] ea, input logic ew);
    @(negedge sys_clock);
    step9 = 1'b1; dir9 = d;
    @(negedge sys_clock);
    step9 = 1'b0;
    @(posedge sys_clock);
    #1;
    chk("last9_addr", 32'(addr9), 32'(ea));
    chk("last9_wrap", 32'(wrap9), 32'(ew));
    chk("last9_state", 32'(state9), 32'(ST_P));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    div_clk_in = 1'b0; run_en = 1'b0; step_req = 1'b0; dir_up = 1'b1;
    div9 = 1'b0; run9 = 1'b0; step9 = 1'b0; dir9 = 1'b1;
    #12;
    chk("reset_outputs", 32'({addr, state, addr_valid, wrap}), 32'h0);
    @(negedge sys_clock);
    reset_n = 1'b1;

    // IDLE -> RUN with a coincident tick: no advance.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, ST_I, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, ST_R, 1'b1, 1'b0);

    // Free run, 1 high / 7 low: 0..15,0 with a single wrap.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'(k), ST_R, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'((k + 1) % 16), ST_R, 1'b1, k == 15);
      for (int j = 0; j < 6; j++)
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'((k + 1) % 16), ST_R, 1'b1, 1'b0);
    end

    // Down-count wrap from 2.
    tk(1'b1, 4'd0, 4'd1, 1'b0);
    tk(1'b1, 4'd1, 4'd2, 1'b0);
    tk(1'b0, 4'd2, 4'd1, 1'b0);
    tk(1'b0, 4'd1, 4'd0, 1'b0);
    tk(1'b0, 4'd0, 4'd15, 1'b1);
    tk(1'b0, 4'd15, 4'd14, 1'b0);
    for (int a = 14; a > 5; a--)
      tk(1'b0, 4'(a), 4'(a - 1), 1'b0);

    // Pause/step and simultaneous-event vectors, starting in RUN at 5.
    add(0,1,0,0, 5, ST_P,1,0);  add(0,1,1,0, 5, ST_P,1,0);  add(0,1,0,0, 5, ST_P,1,0);
    add(0,1,0,1, 5, ST_P,1,0);  add(0,1,0,0, 6, ST_P,1,0);
    add(0,1,0,1, 6, ST_P,1,0);  add(0,1,0,0, 7, ST_P,1,0);
    add(0,1,0,1, 7, ST_P,1,0);  add(0,1,0,0, 8, ST_P,1,0);
    add(1,1,0,0, 8, ST_R,1,0);  add(1,1,1,0, 8, ST_R,1,0);  add(0,1,0,0, 8, ST_P,1,0);
    add(0,1,1,0, 8, ST_P,1,0);  add(1,1,0,0, 8, ST_R,1,0);
    add(1,1,1,1, 8, ST_R,1,0);  add(1,1,0,0, 9, ST_R,1,0);
    add(1,1,0,1, 9, ST_R,1,0);  add(1,1,0,0, 9, ST_R,1,0);
    add(1,1,1,0, 9, ST_R,1,0);  add(1,1,1,0,10, ST_R,1,0);  add(1,1,1,0,10, ST_R,1,0);
    add(1,1,1,0,10, ST_R,1,0);  add(1,1,0,0,10, ST_R,1,0);  add(0,1,0,0,10, ST_P,1,0);
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].run, tbl[i].dir, tbl[i].div, tbl[i].step,
          tbl[i].addr, tbl[i].st, tbl[i].valid, tbl[i].wrap);

    // step_req held for 20 cycles: exactly one advance.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd10, ST_P, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd11, ST_P, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd11, ST_P, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, ST_R, 1'b1, 1'b0);

    // Asynchronous reset between edges while running at 11.
    @(posedge sys_clock);
    #3;
    reset_n = 1'b0;
    run_en = 1'b0; div_clk_in = 1'b0; step_req = 1'b0;
    #1;
    chk("async_reset_addr",  32'(addr), 32'd0);
    chk("async_reset_valid", 32'(addr_valid), 32'd0);
    chk("async_reset_state", 32'(state), 32'(ST_I));
    chk("async_reset_wrap",  32'(wrap), 32'd0);
    @(posedge sys_clock);
    @(negedge sys_clock);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, ST_I, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, ST_I, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, ST_I, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, ST_I, 1'b0, 1'b0);
    // Step from IDLE: PAUSE, addr 1 and addr_valid on the same edge.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, ST_I, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, ST_P, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, ST_R, 1'b1, 1'b0);
    tk(1'b1, 4'd1, 4'd2, 1'b0);

    // LAST_ADDR=9 instance: wraps land on 9 and 0.
    chk("last9_idle_addr", 32'(addr9), 32'd0);
    step9_chk(1'b0, 4'd9, 1'b1);
    step9_chk(1'b1, 4'd0, 1'b1);
    step9_chk(1'b0, 4'd9, 1'b1);
    step9_chk(1'b0, 4'd8, 1'b0);

    @(posedge sys_clock);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
